seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider_pkg.sv | 13 +
 rtl/seq_restoring_divider_div_step.sv | 30 +++
 rtl/seq_restoring_divider.sv | 104 ++++++++++
 tb/tb_seq_restoring_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the default operand width.
package seq_restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift the partial remainder left by one,
// bring in the next dividend bit, and trial-subtract the divisor. The sign of
// the difference selects restore or keep and gives the quotient bit.
module seq_restoring_divider_div_step
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The MSB of rem_in is always 0 because the remainder stays below the
  // divisor, and only WIDTH bits are ever shifted in when the divisor is 0.
  // Keeping it in the shifted word costs nothing and leaves the top bit as a
  // clean sign bit for the trial subtraction.
  always_comb begin
    shifted = {rem_in, shift_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Results are published only when the last
// iteration completes and are held until the next division finishes.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] d_work;
  logic [WIDTH:0]   r_work;
  logic [WIDTH:0]   r_next;
  logic             q_bit;
  logic             dbz_work;
  logic             last_iter;
  logic [WIDTH-1:0] q_next;

  assign last_iter = (count == CNT_W'(1));
  assign q_next    = {q_work[WIDTH-2:0], q_bit};
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  seq_restoring_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in  (r_work),
    .shift_in(q_work[WIDTH-1]),
    .divisor (d_work),
    .rem_out (r_next),
    .q_bit   (q_bit)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic; start is only honoured in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      q_work      <= '0;
      d_work      <= '0;
      r_work      <= '0;
      dbz_work    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_work   <= divisor;
            q_work   <= dividend;
            r_work   <= '0;
            dbz_work <= (divisor == '0);
            count    <= CNT_W'(WIDTH);
          end
        end
        RUN: begin
          r_work <= r_next;
          q_work <= q_next;
          count  <= count - CNT_W'(1);
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= dbz_work;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: accepted requests are predicted
// with plain integer division and queued; a monitor checks each done pulse,
// the busy window, latency and reset behaviour.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = -1;
  bit   b2b = 1'b0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Observer: a start seen while the unit is idle will be accepted on the
  // coming edge; predict its result from the arithmetic definition.
  always @(negedge clk) begin : observer
    exp_t e;
    if (rst_n && start && !busy && !done) begin
      e.a = dividend;
      e.b = divisor;
      if (divisor == '0) begin
        e.q = '1;
        e.r = dividend;
        e.z = 1'b1;
      end else begin
        e.q = dividend / divisor;
        e.r = dividend % divisor;
        e.z = 1'b0;
      end
      e.acc = cyc + 1;
      if (b2b && last_acc >= 0) check("accept_spacing", e.acc - last_acc, W + 2);
      last_acc = e.acc;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare everything the DUT presents against the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   eb;
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      exp_q.delete();
    end else begin
      eb = (exp_q.size() > 0) && (cyc >= exp_q[0].acc) && (cyc < exp_q[0].acc + W);
      check("busy", busy, eb);
      check("busy_done_exclusive", busy && done, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_done");
        end else begin
          e = exp_q.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", div_by_zero, e.z);
          check("latency", cyc - e.acc, W);
          if (!e.z) begin
            check("invariant", int'(quotient) * int'(e.b) + int'(remainder), int'(e.a));
            check("rem_lt_div", remainder < e.b, 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 60) begin
      tick();
      n++;
    end
    if (busy || done) fail_now("idle_timeout");
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    int n = 0;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    if (noise) begin
      while (busy && n < 60) begin
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        tick();
        n++;
      end
      start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed operands, including edge and divide-by-zero cases
    issue(8'd100, 8'd7, 1'b0);
    issue(8'd255, 8'd1, 1'b0);
    issue(8'd3, 8'd200, 1'b0);
    issue(8'd200, 8'd200, 1'b0);
    issue(8'd5, 8'd0, 1'b0);
    issue(8'd100, 8'd7, 1'b1);
    issue(8'd0, 8'd0, 1'b0);
    issue(8'd255, 8'd255, 1'b0);
    issue(8'd0, 8'd9, 1'b0);

    // Abort during the 4th RUN cycle
    wait_idle();
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    issue(8'd50, 8'd6, 1'b0);

    // start held high continuously
    last_acc = -1;
    b2b      = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 62; i++) begin
      dividend = W'($urandom);
      divisor  = W'($urandom);
      tick();
    end
    start = 1'b0;
    b2b   = 1'b0;
    wait_idle();

    // Random sweep
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 3));
        default: b = W'($urandom);
      endcase
      issue(a, b, $urandom_range(0, 4) == 0);
    end

    wait_idle();
    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
